seq_adder: RTL and testbench

- Multi-cycle, parametrised adder/subtractor that adds `seg` bits per clock and ripples the carry through a register between segments.
- Successor to the combinational `adder` (nbit/s/cout). It trades latency for a short carry chain and adds a subtract mode plus a start/busy/done handshake.
- Used as the shared arithmetic unit for sequential datapaths that cannot close timing on a full-width ripple carry.

---
 rtl/seq_adder.sv | 106 ++++++++++
 tb/tb_seq_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder/subtractor, seg bits per clock with the carry held in a register.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seq_adder #(
    parameter int unsigned nbit = 8,
    parameter int unsigned seg  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            sub,
    input  logic [nbit-1:0] a,
    input  logic [nbit-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [nbit-1:0] s,
    output logic            cout
`ifdef ADDER_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int unsigned K  = (seg == 0) ? 1 : nbit / seg;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(K - 1);

    if (nbit < 1 || seg < 1 || ((seg == 0) ? 1 : nbit % seg) != 0) begin : g_bad_param
        $error("seq_adder: nbit must be >= 1 and an integer multiple of seg");
    end

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e          state;
    logic [nbit-1:0] opa;
    logic [nbit-1:0] opb;
    logic [nbit-1:0] acc;
    logic            carry;
    logic [IW-1:0]   idx;

    logic [seg:0]    seg_sum;
    logic [nbit-1:0] acc_next;

    // The final segment is merged here so s can be loaded on the same edge it is computed.
    always_comb begin
        seg_sum  = {1'b0, opa[idx*seg +: seg]} + {1'b0, opb[idx*seg +: seg]}
                 + {{seg{1'b0}}, carry};
        acc_next = acc;
        acc_next[idx*seg +: seg] = seg_sum[seg-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
`ifdef ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= StAdd;
                    end else begin
                        state <= StIdle;
                    end
                end
                StAdd: begin
                    acc   <= acc_next;
                    carry <= seg_sum[seg];
                    if (idx == LastIdx) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= acc_next;
                        cout  <= seg_sum[seg];
`ifdef ADDER_OVF_EN
                        ovf   <= (opa[nbit-1] == opb[nbit-1]) &&
                                 (acc_next[nbit-1] != opa[nbit-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder.sv
// Randomised self-checking bench for seq_adder against an arithmetic reference model.
// Define ADDER_OVF_EN to also check the overflow output.
module tb_seq_adder #(
    parameter int unsigned nbit = 8,
    parameter int unsigned seg  = 2
);

    localparam int unsigned K = nbit / seg;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            sub;
    logic [nbit-1:0] a;
    logic [nbit-1:0] b;
    logic            busy;
    logic            done;
    logic [nbit-1:0] s;
    logic            cout;
`ifdef ADDER_OVF_EN
    logic            ovf;
`endif

    int total = 0;
    int bad   = 0;

    logic [nbit-1:0] cur_s;
    logic            cur_cout;
    logic            cur_ovf;

    seq_adder #(
        .nbit(nbit),
        .seg (seg)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .s    (s),
        .cout (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, "_s"}, s, cur_s);
        check({tag, "_cout"}, cout, cur_cout);
`ifdef ADDER_OVF_EN
        check({tag, "_ovf"}, ovf, cur_ovf);
`endif
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operands.
    task automatic model(input logic [nbit-1:0] x, input logic [nbit-1:0] y, input bit m,
                         output logic [nbit-1:0] rs, output bit rc, output bit ro);
        longint ux, uy, sx, sy, r, smax, smin;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = x[nbit-1] ? ux - (longint'(1) << nbit) : ux;
        sy   = y[nbit-1] ? uy - (longint'(1) << nbit) : uy;
        smax = (longint'(1) << (nbit - 1)) - 1;
        smin = -(longint'(1) << (nbit - 1));
        if (m) begin
            rs = nbit'(ux - uy);
            rc = (ux >= uy);
            r  = sx - sy;
        end else begin
            rs = nbit'(ux + uy);
            rc = ((ux + uy) >> nbit) != 0;
            r  = sx + sy;
        end
        ro = (r > smax) || (r < smin);
    endtask

    task automatic scramble_inputs();
        a   = nbit'($urandom);
        b   = nbit'($urandom);
        sub = 1'($urandom);
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge after the done edge.
    task automatic do_op(input logic [nbit-1:0] x, input logic [nbit-1:0] y, input bit m,
                         input bit hold);
        logic [nbit-1:0] es;
        bit              ec, eo;
        model(x, y, m, es, ec, eo);
        start = 1'b1;
        a     = x;
        b     = y;
        sub   = m;
        @(negedge clk);
        for (int i = 0; i < int'(K); i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check_held("held_run");
            start = hold ? 1'b1 : 1'($urandom);
            scramble_inputs();
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("result_s", s, es);
        check("result_cout", cout, ec);
`ifdef ADDER_OVF_EN
        check("result_ovf", ovf, eo);
`endif
        cur_s    = es;
        cur_cout = ec;
        cur_ovf  = eo;
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        scramble_inputs();
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check_held("held_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, wanted test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;
        cur_s    = '0;
        cur_cout = 1'b0;
        cur_ovf  = 1'b0;

        // Reset with random inputs and start pulses
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check_held("rst");
            start = 1'($urandom);
            scramble_inputs();
        end
        start = 1'b0;
        rst_n = 1'b1;
        idle_cycle();

        do_op(nbit'(8'h5A), nbit'(8'h3C), 1'b0, 1'b0);
        idle_cycle();
        do_op(nbit'(8'hFF), nbit'(8'h01), 1'b0, 1'b0);
        do_op(nbit'(8'hFF), nbit'(8'hFF), 1'b0, 1'b0);
        idle_cycle();
        do_op(nbit'(8'h10), nbit'(8'h01), 1'b1, 1'b0);
        do_op(nbit'(8'h01), nbit'(8'h02), 1'b1, 1'b0);
        idle_cycle();
        do_op('1, nbit'(1), 1'b0, 1'b0);
        do_op('0, nbit'(1), 1'b1, 1'b0);
        idle_cycle();
        do_op(nbit'(8'h7F), nbit'(8'h01), 1'b0, 1'b0);
        do_op(nbit'(8'h80), nbit'(8'h01), 1'b1, 1'b0);
        do_op(nbit'(8'h10), nbit'(8'h10), 1'b0, 1'b0);
        idle_cycle();

        // start held high and operands churning while busy, chained back to back
        for (int i = 0; i < 4; i++)
            do_op(nbit'($urandom), nbit'($urandom), 1'($urandom), 1'b1);
        idle_cycle();

        for (int i = 0; i < 40; i++) begin
            do_op(nbit'($urandom), nbit'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();

        // Abort mid-operation
        start = 1'b1;
        scramble_inputs();
        repeat ((K > 2) ? 2 : 1) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        cur_s    = '0;
        cur_cout = 1'b0;
        cur_ovf  = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check_held("abort");
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            scramble_inputs();
            @(negedge clk);
            check("abort_hold_done", done, 0);
            check("abort_hold_busy", busy, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < int'(K) + 2; i++) idle_cycle();

        do_op(nbit'($urandom), nbit'($urandom), 1'b0, 1'b0);
        do_op(nbit'($urandom), nbit'($urandom), 1'b1, 1'b0);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
